// File: rtl/instruction_fetch_queue_pkg.sv
// Shared fetch/decode definitions: fetch FSM encodings, the halt word and
// the MIPS instruction field positions that decode slices out of o_instr.
package mips_fetch_pkg;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t S_IDLE = 2'd0;
    localparam fetch_state_t S_RUN  = 2'd1;
    localparam fetch_state_t S_HALT = 2'd2;

    localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int JADDR_MSB  = 25;
    localparam int JADDR_LSB  = 0;

    function automatic logic [5:0] instr_opcode(input logic [31:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/instruction_fetch_queue_if.sv
// Fetch-side buses: fixed-latency instruction memory port and the
// valid/ready instruction stream toward decode.
interface instruction_fetch_queue_if #(
    parameter int NB_INSTR = 32,
    parameter int NB_PC    = 32
);
    logic                o_imem_en;
    logic [NB_PC-1:0]    o_imem_addr;
    logic [NB_INSTR-1:0] i_imem_data;
    logic                o_valid;
    logic                i_ready;
    logic [NB_INSTR-1:0] o_instr;
    logic [NB_PC-1:0]    o_pc_plus4;

    modport master (
        output o_imem_en, o_imem_addr, o_valid, o_instr, o_pc_plus4,
        input  i_imem_data, i_ready
    );

    modport slave (
        input  o_imem_en, o_imem_addr, o_valid, o_instr, o_pc_plus4,
        output i_imem_data, i_ready
    );
endinterface

// File: rtl/instruction_fetch_queue_fifo.sv
// Small register-based instruction queue with a combinational head read.
// Flush wins over push and pop; a push into a full queue lands when a pop frees a slot.
module fetch_fifo #(
    parameter int FQ_DEPTH  = 4,
    parameter int NB_DATA   = 64,
    parameter int NB_FQ_CNT = $clog2(FQ_DEPTH) + 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 flush,
    input  logic [NB_DATA-1:0]   wr_data,
    output logic [NB_DATA-1:0]   rd_data,
    output logic                 empty,
    output logic [NB_FQ_CNT-1:0] count
);
    import mips_fetch_pkg::*;

    localparam int NB_PTR = $clog2(FQ_DEPTH);

    logic [NB_PTR-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [NB_PTR-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [NB_FQ_CNT-1:0] count_reg, count_next;
    logic                 full, do_push, do_pop;
    logic [NB_DATA-1:0]   entry_q [FQ_DEPTH];

    assign full    = (count_reg == NB_FQ_CNT'(FQ_DEPTH));
    assign empty   = (count_reg == '0);
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & ~flush & (~full | do_pop);

    genvar gi;
    generate
        for (gi = 0; gi < FQ_DEPTH; gi++) begin : g_entry
            logic [NB_DATA-1:0] data_reg;
            always_ff @(posedge i_clk) begin
                if (do_push && (wr_ptr_reg == NB_PTR'(gi))) begin
                    data_reg <= wr_data;
                end
            end
            assign entry_q[gi] = data_reg;
        end
    endgenerate

    assign rd_data = entry_q[rd_ptr_reg];
    assign count   = count_reg;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (do_push) wr_ptr_next = wr_ptr_reg + NB_PTR'(1);
            if (do_pop)  rd_ptr_next = rd_ptr_reg + NB_PTR'(1);
            if (do_push && !do_pop) begin
                count_next = count_reg + NB_FQ_CNT'(1);
            end else if (do_pop && !do_push) begin
                count_next = count_reg - NB_FQ_CNT'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end
endmodule

// File: rtl/instruction_fetch_queue.sv
// MIPS fetch stage: issues fixed-latency instruction reads against queue credit,
// buffers responses for decode, flushes on redirect and parks on a halt word.
module instruction_fetch_queue #(
    parameter int                  NB_INSTR   = 32,
    parameter int                  NB_PC      = 32,
    parameter int                  PC_STEP    = 1,
    parameter int                  FQ_DEPTH   = 4,
    parameter int                  NB_FQ_CNT  = $clog2(FQ_DEPTH) + 1,
    parameter logic [NB_INSTR-1:0] HALT_INSTR = NB_INSTR'(mips_fetch_pkg::HALT_INSTR)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_pipe_enabled,
    input  logic                      i_pc_sel_branch,
    input  logic                      i_pc_sel_jump,
    input  logic [NB_PC-1:0]          i_pc_addr_branch,
    input  logic [NB_PC-1:0]          i_pc_addr_jump,
    instruction_fetch_queue_if.master bus,
    output logic [NB_PC-1:0]          o_rf_pc_count,
    output logic [NB_FQ_CNT-1:0]      o_fq_count,
    output logic                      o_halted
);
    import mips_fetch_pkg::*;

    localparam logic [NB_PC-1:0] PC_INC = NB_PC'(PC_STEP);

    fetch_state_t          state_reg, state_next;
    logic [NB_PC-1:0]      pc_reg, pc_next;
    logic [NB_PC-1:0]      req_pc_plus_reg;
    logic                  inflight_reg, drop_reg, drop_next;
    logic                  redirect, issue, resp_ok, halt_hit;
    logic                  fq_push, fq_pop, fq_empty;
    logic [NB_PC-1:0]      redirect_target;
    logic [NB_FQ_CNT:0]    credit_used;
    logic [NB_FQ_CNT-1:0]  fq_count;
    logic [NB_INSTR+NB_PC-1:0] fq_rd_data;

    assign redirect        = i_pipe_enabled & (i_pc_sel_branch | i_pc_sel_jump);
    assign redirect_target = i_pc_sel_branch ? i_pc_addr_branch : i_pc_addr_jump;

    // A halt word also blocks this cycle's issue so nothing is left in flight behind it.
    assign resp_ok  = inflight_reg & ~drop_reg;
    assign halt_hit = resp_ok & (bus.i_imem_data == HALT_INSTR);
    assign fq_push  = resp_ok & ~halt_hit;

    assign credit_used = {1'b0, fq_count} + {{NB_FQ_CNT{1'b0}}, inflight_reg};
    assign issue = (state_reg == S_RUN) & i_pipe_enabled & ~redirect & ~halt_hit
                 & (credit_used < (NB_FQ_CNT+1)'(FQ_DEPTH));

    assign bus.o_imem_en   = issue;
    assign bus.o_imem_addr = pc_reg;
    assign bus.o_valid     = ~fq_empty & ~redirect & i_pipe_enabled;
    assign fq_pop          = bus.o_valid & bus.i_ready;
    assign {bus.o_instr, bus.o_pc_plus4} = fq_rd_data;

    assign o_rf_pc_count = pc_reg;
    assign o_fq_count    = fq_count;
    assign o_halted      = (state_reg == S_HALT) & (fq_count == '0) & ~inflight_reg;

    fetch_fifo #(
        .FQ_DEPTH  (FQ_DEPTH),
        .NB_DATA   (NB_INSTR + NB_PC),
        .NB_FQ_CNT (NB_FQ_CNT)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .push    (fq_push),
        .pop     (fq_pop),
        .flush   (redirect),
        .wr_data ({bus.i_imem_data, req_pc_plus_reg}),
        .rd_data (fq_rd_data),
        .empty   (fq_empty),
        .count   (fq_count)
    );

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        drop_next  = drop_reg;
        if (redirect) begin
            state_next = S_RUN;
            pc_next    = redirect_target;
            drop_next  = issue;
        end else begin
            if (halt_hit) begin
                state_next = S_HALT;
            end else if ((state_reg == S_IDLE) && i_pipe_enabled) begin
                state_next = S_RUN;
            end
            if (issue) pc_next = pc_reg + PC_INC;
            if (inflight_reg) drop_next = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg       <= S_IDLE;
            pc_reg          <= '0;
            inflight_reg    <= 1'b0;
            drop_reg        <= 1'b0;
            req_pc_plus_reg <= '0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            inflight_reg <= issue;
            drop_reg     <= drop_next;
            if (issue) req_pc_plus_reg <= pc_reg + PC_INC;
        end
    end
endmodule
